// File: rtl/mlh_pkg.sv
// Shared word geometry for the 128-bit byte mux / byte packer pair.
// Byte k of a word always occupies bits [8k+7:8k].
package mlh_pkg;

  localparam int WORD_BYTES = 16;
  localparam int IDX_W      = 4;
  localparam int WORD_W     = 128;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage : mlh_pkg

// File: rtl/byte_packer_if.sv
// Byte-in / word-out handshake bundle for the byte packer.
// The slave modport is the packer; the master modport is its environment.
interface byte_packer_if
  import mlh_pkg::*;
;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [WORD_W-1:0]     out_data;
  logic [WORD_BYTES-1:0] out_be;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_be, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_be, out_last, out_valid
  );

endinterface : byte_packer_if

// File: rtl/byte_packer.sv
// Packs a byte stream into 128-bit words, byte k into lane k, with an
// early flush on in_last. Input and output phases never overlap.
module byte_packer
  import mlh_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  byte_packer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [WORD_W-1:0]     data_q,  data_d;
  logic [WORD_BYTES-1:0] be_q,    be_d;
  logic                  last_q,  last_d;
  logic                  in_xfer;

  assign in_xfer = bus.in_valid && (state_q == FILL);

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    be_d    = be_q;
    last_d  = last_q;

    unique case (state_q)
      FILL: begin
        if (in_xfer) begin
          data_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          be_d[idx_q]                  = 1'b1;
          idx_d                        = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX || bus.in_last) begin
            state_d = FULL;
            last_d  = bus.in_last;
            idx_d   = '0;
          end
        end
      end
      FULL: begin
        // Data lanes are left as-is; be marks which of them are meaningful.
        if (bus.out_ready) begin
          state_d = FILL;
          be_d    = '0;
          last_d  = 1'b0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      // NOTE: the data register is cleared too, so out_data is a known zero
      // after reset rather than stale lanes from a discarded word.
      data_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      be_q    <= be_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_be    = be_q;
  assign bus.out_last  = last_q;

endmodule : byte_packer

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: a byte-queue reference model predicts
// each emitted word; per-scenario tasks compare observed words against it.
module tb_byte_packer;
  import mlh_pkg::*;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  be;
    logic         last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] cur_q[$];   // bytes accepted into the word being built
  word_t      exp_q[$];   // words the model says must come out
  word_t      obs_q[$];   // words the DUT handed over

  byte_packer_if bus ();

  byte_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Outputs are stable between edges; a word held with out_ready high at the
  // falling edge is consumed on the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      obs_q.push_back('{data: bus.out_data, be: bus.out_be, last: bus.out_last});
  end

  function automatic logic [127:0] be_mask(input logic [15:0] be);
    logic [127:0] m = '0;
    for (int k = 0; k < 16; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [7:0] mux_sel(input logic [127:0] w, input int s);
    return w[8*s +: 8];
  endfunction

  // Reference model: collect bytes, emit a word at 16 bytes or on last.
  function automatic void model_accept(input logic [7:0] d, input logic l);
    word_t w;
    int    n;
    cur_q.push_back(d);
    if (cur_q.size() == 16 || l) begin
      n      = cur_q.size();
      w.data = '0;
      for (int k = 0; k < n; k++) w.data[8*k +: 8] = cur_q[k];
      w.be   = 16'(((17'd1) << n) - 17'd1);
      w.last = l;
      exp_q.push_back(w);
      cur_q.delete();
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    logic acc;
    int   budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    do begin
      acc = bus.in_ready;
      cycle();
      budget++;
    end while (!acc && budget < 200);
    if (acc) model_accept(d, l);
    else begin
      checks++; errors++;
      $display("FAIL push_timeout: byte %h not accepted in 200 cycles", d);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_words(input int n, input string name);
    int budget = 0;
    while (obs_q.size() < n && budget < 200) begin
      cycle();
      budget++;
    end
    if (obs_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d words, expected %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    checks += 5;
    if (bus.in_ready  !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); end
    if (bus.out_be    !== 16'h0) begin errors++; $display("FAIL rst_out_be: got %h exp 0000", bus.out_be); end
    if (bus.out_last  !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b exp 0", bus.out_last); end
    if (bus.out_data  !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %h exp 0", bus.out_data); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_full_word();
    word_t o, e;
    logic [127:0] m;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) push_byte(8'(255 - 17 * k), 1'b0);
    wait_words(1, "full");
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      m = be_mask(e.be);
      checks += 3;
      if (o.data !== 128'h00112233445566778899AABBCCDDEEFF || o.be !== 16'hFFFF || o.last !== 1'b0) begin
        errors++;
        $display("FAIL full_const: got data=%h be=%h last=%b", o.data, o.be, o.last);
      end
      if ({o.data & m, o.be, o.last} !== {e.data & m, e.be, e.last}) begin
        errors++;
        $display("FAIL full_model: got %h/%h/%b exp %h/%h/%b", o.data & m, o.be, o.last, e.data & m, e.be, e.last);
      end
      for (int k = 0; k < 16; k++) begin
        if (mux_sel(o.data, k) !== 8'(255 - 17 * k)) begin
          errors++;
          $display("FAIL full_mux_sel%0d: got %h exp %h", k, mux_sel(o.data, k), 8'(255 - 17 * k));
        end
      end
      checks += 15;
    end
  endtask

  task automatic test_partial();
    word_t o, e;
    logic [127:0] m;
    bus.out_ready = 1'b1;
    push_byte(8'h0A, 1'b0);
    push_byte(8'h0B, 1'b0);
    push_byte(8'h0C, 1'b1);
    push_byte(8'h5A, 1'b1);  // must land in lane 0 of a fresh word
    wait_words(2, "partial");
    for (int w = 0; w < 2 && obs_q.size() > 0 && exp_q.size() > 0; w++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      m = be_mask(e.be);
      checks += 2;
      if ({o.data & m, o.be, o.last} !== {e.data & m, e.be, e.last}) begin
        errors++;
        $display("FAIL partial_model%0d: got %h/%h/%b exp %h/%h/%b", w, o.data & m, o.be, o.last, e.data & m, e.be, e.last);
      end
      if (w == 0 && (o.be !== 16'h0007 || o.data[23:0] !== 24'h0C0B0A || o.last !== 1'b1)) begin
        errors++;
        $display("FAIL partial_const: got be=%h data=%h last=%b exp 0007/0c0b0a/1", o.be, o.data[23:0], o.last);
      end
      if (w == 1 && (o.be !== 16'h0001 || o.data[7:0] !== 8'h5A)) begin
        errors++;
        $display("FAIL partial_idx_restart: got be=%h lane0=%h exp 0001/5a", o.be, o.data[7:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    word_t o, e;
    logic [127:0] m, cap_data;
    logic [15:0]  cap_be;
    logic         cap_last;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) push_byte(8'($urandom), 1'b0);
    cap_data = bus.out_data;
    cap_be   = bus.out_be;
    cap_last = bus.out_last;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'b1;
      checks += 3;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b exp 1", c, bus.out_valid); end
      if ({bus.out_data, bus.out_be, bus.out_last} !== {cap_data, cap_be, cap_last}) begin
        errors++; $display("FAIL bp_stable c%0d: got %h/%h exp %h/%h", c, bus.out_data, bus.out_be, cap_data, cap_be);
      end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b exp 0", c, bus.in_ready); end
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b1);
    wait_words(2, "bp");
    for (int w = 0; w < 2 && obs_q.size() > 0 && exp_q.size() > 0; w++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      m = be_mask(e.be);
      checks++;
      if ({o.data & m, o.be, o.last} !== {e.data & m, e.be, e.last}) begin
        errors++;
        $display("FAIL bp_model%0d: got %h/%h/%b exp %h/%h/%b", w, o.data & m, o.be, o.last, e.data & m, e.be, e.last);
      end
    end
  endtask

  task automatic test_gapped();
    word_t o, e;
    logic [127:0] m;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_data = 8'($urandom);  // noise while in_valid is low
        bus.in_last = 1'($urandom);
        cycle();
      end
      bus.in_last = 1'b0;
      push_byte(8'($urandom), 1'b0);
    end
    wait_words(2, "gapped");
    repeat (3) cycle();
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL gapped_count: got %0d words exp 2", obs_q.size()); end
    for (int w = 0; w < 2 && obs_q.size() > 0 && exp_q.size() > 0; w++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      m = be_mask(e.be);
      checks++;
      if ({o.data & m, o.be, o.last} !== {e.data & m, e.be, e.last}) begin
        errors++;
        $display("FAIL gapped_model%0d: got %h/%h/%b exp %h/%h/%b", w, o.data & m, o.be, o.last, e.data & m, e.be, e.last);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    word_t o, e;
    logic [127:0] m;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) push_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cur_q.delete();
    for (int k = 0; k < 16; k++) push_byte(8'($urandom), 1'b0);
    wait_words(1, "rst_mid");
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      m = be_mask(e.be);
      checks += 2;
      if ({o.data & m, o.be, o.last} !== {e.data & m, e.be, e.last}) begin
        errors++;
        $display("FAIL rst_mid_model: got %h/%h/%b exp %h/%h/%b", o.data & m, o.be, o.last, e.data & m, e.be, e.last);
      end
      if (o.be !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_be: got %h exp ffff", o.be); end
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) push_byte(8'($urandom), 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_full_pre: got out_valid %b exp 1", bus.out_valid); end
    bus.out_ready = 1'b1;  // reset must win over the handshake
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_full_valid: got %b exp 0", bus.out_valid); end
    if (bus.in_ready  !== 1'b1) begin errors++; $display("FAIL rst_full_in_ready: got %b exp 1", bus.in_ready); end
    if (bus.out_be    !== 16'h0) begin errors++; $display("FAIL rst_full_be: got %h exp 0000", bus.out_be); end
  endtask

  task automatic test_last16();
    word_t o, e;
    logic [127:0] m;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) push_byte(8'($urandom), 1'(k == 15));
    wait_words(1, "last16");
    repeat (5) cycle();
    checks += 2;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL last16_count: got %0d words exp 1", obs_q.size()); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL last16_idle: got out_valid %b exp 0", bus.out_valid); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      m = be_mask(e.be);
      checks += 2;
      if ({o.data & m, o.be, o.last} !== {e.data & m, e.be, e.last}) begin
        errors++;
        $display("FAIL last16_model: got %h/%h/%b exp %h/%h/%b", o.data & m, o.be, o.last, e.data & m, e.be, e.last);
      end
      if (o.be !== 16'hFFFF || o.last !== 1'b1) begin
        errors++; $display("FAIL last16_const: got be=%h last=%b exp ffff/1", o.be, o.last);
      end
    end
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_last16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_byte_packer

// File: doc/byte_packer.md
# byte_packer

Sequential counterpart of the 128-to-8 byte mux: accepts a stream of bytes and packs them into 128-bit words. Byte index k lands in bits [8k+7:8k], the same lane that select value k picks out on the mux side. A mux and packer pair therefore round-trips a word unchanged. It sits between byte-wide producers (serial front-ends, test stimulus) and 128-bit datapath consumers, with valid/ready handshakes on both sides and an early-flush path for partial words.

## Interface
Parameters:
- none; word geometry comes from the shared package (16 bytes, 4-bit index).

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  8  input byte.
- in_valid  in  1  input byte present.
- in_last  in  1  qualifies in_data as the final byte of a packet; forces word emission.
- in_ready  out  1  packer can accept a byte this cycle.
- out_data  out  128  packed word; byte k at [8k+7:8k].
- out_be  out  16  byte-enable; bit k set if byte k holds valid data.
- out_last  out  1  word ends a packet.
- out_valid  out  1  word present.
- out_ready  in  1  consumer accepts the word.

## Operation
- Two states:
  - FILL: accepting bytes.
  - FULL: holding a word for output.
- Input handshake:
  - An input transfer occurs when in_valid && in_ready.
  - in_ready = (state == FILL).
- FILL, on each input transfer:
  - Write in_data into lane idx.
  - Set be[idx].
  - idx <= idx+1, wrapping modulo 16.
  - If idx == 15 or in_last: go to FULL, latch last = in_last, and reset idx to 0.
- FULL:
  - out_valid = 1.
  - out_data, out_be and out_last are held stable until out_ready.
  - On out_ready: clear be and last, then return to FILL.
  - Data lanes are not cleared; lanes with be=0 are don't-care, and the bench must mask them.
- Word contents:
  - A full word has out_be = 16'hFFFF.
  - A partial word (in_last before 16 bytes) has out_be = (1<<n)-1 for n bytes.
- in_last on byte 16 emits out_be = FFFF with out_last = 1.
- There is no zero-byte word: out_last can only be set by a transferred byte.
- in_data and in_last are ignored when in_valid = 0.
- Reset, including mid-word or while FULL:
  - state = FILL, idx = 0, be = 0, last = 0.
  - Any partial or pending word is discarded.
  - Reset takes priority over any handshake in the same cycle.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_be = 0.
  - out_last = 0.
  - out_data = 0 (data register cleared on reset).
- Latency: out_valid rises in the cycle after the accepting edge of the 16th byte (or the last byte). All outputs are registered.
- Throughput:
  - A full word takes 16 input cycles plus at least 1 output cycle.
  - in_ready is low while FULL, so there is no input/output overlap.
  - The best case is 17 cycles per word.
- Backpressure: out_valid stays asserted with stable outputs for any number of cycles that out_ready is low.
- out_ready is a don't-care while out_valid = 0.

## Structure
- Shared package `mlh_pkg`:
  - WORD_BYTES = 16.
  - IDX_W = 4.
  - WORD_W = 128.
  - State enum {FILL, FULL}.
  - The mux uses the same constants.
- Single module, no sub-modules. The 4-bit index counter and lane write-decoder are inline; a separate counter module is not warranted.

## Test plan
- Full word: feed bytes FF,EE,DD,…,00 (k=0..15) with out_ready=1.
  - Expect out_data = 128'h00112233445566778899AABBCCDDEEFF.
  - Expect out_be = FFFF and out_last = 0.
  - Then feed that word through the mux and check that sel k returns byte k.
- Partial flush: 3 bytes 0A,0B,0C, the third with in_last.
  - Expect out_be = 0007, out_data[23:0] = 0C0B0A, out_last = 1.
  - Expect idx back at 0 for the next byte.
- Backpressure: hold out_ready=0 for 10 cycles after a full word.
  - out_valid stays 1 and outputs are stable.
  - in_ready stays 0, and bytes offered with in_valid are not consumed.
  - When released, the next word starts at lane 0.
- Gapped input: toggle in_valid randomly across 32 bytes.
  - Expect two words with correct lane order.
  - No byte is lost or duplicated.
- Reset mid-operation:
  - Assert rst after 7 bytes, then send 16 fresh bytes. The first output word holds only the fresh bytes, and out_be = FFFF.
  - Assert rst while FULL. Expect out_valid = 0 on the next cycle.
- Last on 16th byte: expect out_be = FFFF and out_last = 1 in a single word, with no extra empty word.
